// File: rtl/vend_pkg.sv
// Shared types for the ticket vending path.
// State encoding and request codes used by the coin FSM and dispenser.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TKT_RUN = 3'd1,
    ST_CHG_RUN = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAULT   = 3'd4
  } vend_state_e;

  // Request bit masks on the {balance, ticket} pulse pair
  localparam logic [1:0] REQ_NONE    = 2'b00;
  localparam logic [1:0] REQ_TICKET  = 2'b01;
  localparam logic [1:0] REQ_BALANCE = 2'b10;

  function automatic logic req_hit(
    input logic [1:0] req,
    input logic [1:0] mask
  );
    return |(req & mask);
  endfunction

endpackage

// File: rtl/vend_pend_cnt.sv
// Saturating up/down pending-request counter.
// Simultaneous inc and dec leave the count unchanged.
module vend_pend_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign sat_o = &cnt_q;
  assign cnt_o = cnt_q;

  // Next count: increment below saturation, decrement above zero
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// Ticket/change dispenser: queues requests, drives one mechanism at a time,
// waits for sense with a timeout, then enforces an idle gap.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ticket,
  input  logic             balance,
  input  logic             tkt_sense,
  input  logic             chg_sense,
  input  logic             fault_clr,
  output logic             tkt_drive,
  output logic             chg_drive,
  output logic [CNT_W-1:0] tkt_pend,
  output logic [CNT_W-1:0] chg_pend,
  output logic             busy,
  output logic             fault,
  output logic             overflow
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int HW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] H_LOAD = HW'(GAP - 1);

  vend_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic [HW-1:0] hold_q;
  logic          tkt_drive_q;
  logic          chg_drive_q;
  logic          busy_q;
  logic          fault_q;
  logic          ovf_q;

  logic [1:0]    req;
  logic          tkt_inc;
  logic          chg_inc;
  logic          tkt_dec;
  logic          chg_dec;
  logic          tkt_sat;
  logic          chg_sat;
  logic          drop;

  assign req     = {balance, ticket};
  assign tkt_inc = req_hit(req, REQ_TICKET);
  assign chg_inc = req_hit(req, REQ_BALANCE);
  assign tkt_dec = (state_q == ST_TKT_RUN) && tkt_sense;
  assign chg_dec = (state_q == ST_CHG_RUN) && chg_sense;
  assign drop    = (tkt_inc && !tkt_dec && tkt_sat) ||
                   (chg_inc && !chg_dec && chg_sat);

  vend_pend_cnt #(.W(CNT_W)) u_tkt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (tkt_inc),
    .dec_i (tkt_dec),
    .cnt_o (tkt_pend),
    .sat_o (tkt_sat)
  );

  vend_pend_cnt #(.W(CNT_W)) u_chg_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (chg_inc),
    .dec_i (chg_dec),
    .cnt_o (chg_pend),
    .sat_o (chg_sat)
  );

  // Sticky overflow; a new drop wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (fault_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // Dispense FSM with registered drive/busy/fault outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      hold_q      <= '0;
      tkt_drive_q <= 1'b0;
      chg_drive_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (tkt_pend != '0) begin
            state_q     <= ST_TKT_RUN;
            tkt_drive_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (chg_pend != '0) begin
            state_q     <= ST_CHG_RUN;
            chg_drive_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_TKT_RUN: begin
          if (tkt_sense) begin
            state_q     <= ST_HOLD;
            tkt_drive_q <= 1'b0;
            hold_q      <= H_LOAD;
          end else if (timer_q == T_LAST) begin
            state_q     <= ST_FAULT;
            tkt_drive_q <= 1'b0;
            fault_q     <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_CHG_RUN: begin
          if (chg_sense) begin
            state_q     <= ST_HOLD;
            chg_drive_q <= 1'b0;
            hold_q      <= H_LOAD;
          end else if (timer_q == T_LAST) begin
            state_q     <= ST_FAULT;
            chg_drive_q <= 1'b0;
            fault_q     <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          tkt_drive_q <= 1'b0;
          chg_drive_q <= 1'b0;
          busy_q      <= 1'b0;
          fault_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tkt_drive = tkt_drive_q;
  assign chg_drive = chg_drive_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed self-checking bench for vend_dispenser.
// Expected values are hand-derived from the dispenser behaviour.
module tb_vend_dispenser;

  logic       clk;
  logic       rst;
  logic       ticket;
  logic       balance;
  logic       tkt_sense;
  logic       chg_sense;
  logic       fault_clr;
  logic       tkt_drive;
  logic       chg_drive;
  logic [2:0] tkt_pend;
  logic [2:0] chg_pend;
  logic       busy;
  logic       fault;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int hi;
  int n;
  logic both_seen = 1'b0;

  vend_dispenser #(.CNT_W(3), .TIMEOUT(255), .GAP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ticket    (ticket),
    .balance   (balance),
    .tkt_sense (tkt_sense),
    .chg_sense (chg_sense),
    .fault_clr (fault_clr),
    .tkt_drive (tkt_drive),
    .chg_drive (chg_drive),
    .tkt_pend  (tkt_pend),
    .chg_pend  (chg_pend),
    .busy      (busy),
    .fault     (fault),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tkt_drive && chg_drive) both_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_gap();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst = 1'b1; ticket = 0; balance = 0;
    tkt_sense = 0; chg_sense = 0; fault_clr = 0;
    tick(); tick();
    chk("rst_tkt_drive", tkt_drive, 0);
    chk("rst_chg_drive", chg_drive, 0);
    chk("rst_tkt_pend", tkt_pend, 0);
    chk("rst_chg_pend", chg_pend, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // Single ticket
    ticket = 1; tick(); ticket = 0;
    chk("single_pend1", tkt_pend, 1);
    chk("single_drive_early", tkt_drive, 0);
    tick();
    chk("single_drive_up", tkt_drive, 1);
    chk("single_busy", busy, 1);
    hi = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tkt_drive) hi++;
    end
    tkt_sense = 1; tick(); tkt_sense = 0;
    chk("single_high_cycles", hi, 5);
    chk("single_drive_down", tkt_drive, 0);
    chk("single_pend0", tkt_pend, 0);
    tick(); tick(); tick();
    chk("single_hold_busy", busy, 1);
    tick();
    chk("single_idle", busy, 0);

    // Priority: ticket before change
    ticket = 1; balance = 1; tick(); ticket = 0; balance = 0;
    chk("prio_tkt_pend", tkt_pend, 1);
    chk("prio_chg_pend", chg_pend, 1);
    tick();
    chk("prio_tkt_first", tkt_drive, 1);
    chk("prio_chg_off", chg_drive, 0);
    tick();
    tkt_sense = 1; tick(); tkt_sense = 0;
    chk("prio_tkt_done", tkt_drive, 0);
    n = 0;
    while (!chg_drive && n < 20) begin
      tick();
      n++;
    end
    chk("prio_gap_edges", n, 5);
    chk("prio_chg_pend_run", chg_pend, 1);
    tick();
    chg_sense = 1; tick(); chg_sense = 0;
    chk("prio_chg_done", chg_drive, 0);
    chk("prio_chg_pend0", chg_pend, 0);
    wait_gap();
    chk("prio_idle", busy, 0);

    // Timeout then retry
    ticket = 1; tick(); ticket = 0;
    tick();
    hi = tkt_drive ? 1 : 0;
    n = 0;
    while (tkt_drive && n < 300) begin
      tick();
      n++;
      if (tkt_drive) hi++;
    end
    chk("to_high_cycles", hi, 255);
    chk("to_fault", fault, 1);
    chk("to_pend", tkt_pend, 1);
    chk("to_busy", busy, 1);
    tick();
    chk("to_fault_stays", fault, 1);
    fault_clr = 1; tick(); fault_clr = 0;
    chk("to_clr_fault", fault, 0);
    chk("to_clr_drive", tkt_drive, 0);
    tick();
    chk("to_retry_drive", tkt_drive, 1);
    tick();
    tkt_sense = 1; tick(); tkt_sense = 0;
    chk("to_retry_pend0", tkt_pend, 0);
    wait_gap();
    chk("to_idle", busy, 0);

    // Saturation
    ticket = 1;
    for (int i = 0; i < 9; i++) tick();
    ticket = 0;
    chk("sat_pend", tkt_pend, 7);
    chk("sat_overflow", overflow, 1);
    tick();
    chk("sat_sticky", overflow, 1);
    fault_clr = 1; tick(); fault_clr = 0;
    chk("sat_clr_overflow", overflow, 0);
    chk("sat_pend_kept", tkt_pend, 7);
    chk("sat_no_fault", fault, 0);
    chk("sat_still_run", tkt_drive, 1);

    // Simultaneous inc/dec
    rst = 1; tick(); rst = 0;
    ticket = 1; tick(); tick(); ticket = 0;
    chk("sim_pend2", tkt_pend, 2);
    chk("sim_drive", tkt_drive, 1);
    tick();
    ticket = 1; tkt_sense = 1; tick(); ticket = 0; tkt_sense = 0;
    chk("sim_pend_same", tkt_pend, 2);
    chk("sim_drive_down", tkt_drive, 0);

    // Reset mid change run
    rst = 1; tick(); rst = 0;
    balance = 1; tick(); tick(); tick(); balance = 0;
    chk("rr_chg_drive", chg_drive, 1);
    chk("rr_chg_pend", chg_pend, 3);
    #2;
    rst = 1;
    #1;
    chk("rr_async_drive", chg_drive, 0);
    chk("rr_chg_pend0", chg_pend, 0);
    chk("rr_tkt_pend0", tkt_pend, 0);
    chk("rr_busy", busy, 0);
    chk("rr_fault", fault, 0);
    tick();
    rst = 0;
    tick();

    chk("never_both_drives", both_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
